// File: rtl/cart_spi_pkg.sv
// Opcodes and FSM states shared by the cartridge SPI loader.
package cart_spi_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RUN   = 8'hAB;
    localparam logic [7:0] CMD_HALT  = 8'hB9;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, DATA, RDATA, IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// One SPI pin: SYNC_STAGES-deep synchronizer plus rise/fall pulses from the last two samples.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/cart_spi_loader.sv
// SPI mode-0 responder that streams a cartridge image into the ROM and gates CPU reset.
// Define CART_SPI_READBACK_EN to add the 0x03 READ command driving spi_miso.
module cart_spi_loader
    import cart_spi_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              hold_cpu,
    output logic              busy
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_rise, sck_fall, mosi_lvl;
    logic unused_sck_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .pin(spi_cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .pin(spi_sck),
        .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .pin(spi_mosi),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        addr_hi;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        byte_val;
    logic [ADDR_W-1:0] addr_new;
    logic              bit_rise, byte_done, is_read;

    // Rises are ignored in IDLE; a byte landing with the cs rise is still committed.
    assign byte_val  = {shreg[6:0], mosi_lvl};
    assign addr_new  = ADDR_W'({addr_hi, byte_val});
    assign bit_rise  = sck_rise && (state != IDLE);
    assign byte_done = bit_rise && (bit_cnt == 3'd7);
    assign busy      = ~cs_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            addr_hi  <= '0;
            addr     <= '0;
            is_read  <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            hold_cpu <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            if (bit_rise) begin
                shreg   <= byte_val;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                case (state)
                    CMD: begin
                        case (byte_val)
                            CMD_WRITE: state <= ADDR_HI;
`ifdef CART_SPI_READBACK_EN
                            CMD_READ: begin
                                state   <= ADDR_HI;
                                is_read <= 1'b1;
                            end
`endif
                            CMD_RUN: begin
                                hold_cpu <= 1'b0;
                                state    <= IGNORE;
                            end
                            CMD_HALT: begin
                                hold_cpu <= 1'b1;
                                state    <= IGNORE;
                            end
                            default: state <= IGNORE;
                        endcase
                    end
                    ADDR_HI: begin
                        addr_hi <= byte_val;
                        state   <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr  <= addr_new;
                        state <= is_read ? RDATA : DATA;
                    end
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= byte_val;
                        addr    <= addr + ADDR_W'(1);
                    end
                    RDATA:   addr <= addr + ADDR_W'(1);
                    default: ;
                endcase
            end
            if (cs_fall) begin
                state   <= CMD;
                bit_cnt <= '0;
                is_read <= 1'b0;
            end else if (cs_rise) begin
                state <= IDLE;
            end
        end
    end

`ifdef CART_SPI_READBACK_EN
    logic [7:0] tx_sr;
    logic [1:0] ld_pipe;
    logic       ld_start, armed;

    // ROM answers one clk after rd_addr, so the shift register loads two clks after the address update.
    assign ld_start = byte_done && ((state == ADDR_LO && is_read) || state == RDATA);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
            tx_sr   <= '0;
            ld_pipe <= '0;
            armed   <= 1'b0;
        end else begin
            ld_pipe <= {ld_pipe[0], ld_start};
            if (ld_pipe[1]) begin
                tx_sr <= rd_data;
                armed <= 1'b0;
            end else if (state == RDATA && sck_fall && armed) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
            // Only falls that follow a rise of the current byte shift; the fall after bit 8 must not.
            if (byte_done && state == ADDR_LO) begin
                rd_addr <= addr_new;
            end else if (byte_done && state == RDATA) begin
                rd_addr <= addr + ADDR_W'(1);
                armed   <= 1'b0;
            end else if (bit_rise && state == RDATA) begin
                armed <= 1'b1;
            end
        end
    end

    assign spi_miso = (state == RDATA) & tx_sr[7];
`else
    logic unused_rd;
    assign unused_rd = ^{rd_data, sck_fall, is_read};
    assign spi_miso  = 1'b0;
    assign rd_addr   = '0;
`endif

endmodule
